// File: rtl/popcount_expander_pkg.sv
// Shared definitions for the popcount expander: default frame length,
// count-width helper and the FSM state encoding.
package popcount_expander_pkg;

  localparam int N_DEFAULT = 5;

  // Width needed to hold a count in 0..n
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/popcount_expander_idx.sv
// Bit-index counter for the expander frame. Produces the frame position
// used for the ones/zeros compare and the last-bit marker.
// Optional feature macro: POPCOUNT_EXPANDER_ROTATE_EN adds a rotation offset
// that advances once per completed frame, so the ones move cyclically.
module popcount_expander_idx
  import popcount_expander_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = count_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] pos,
  output logic          last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic [CW-1:0] idx;

  assign last = (idx == LAST_IDX);

  // Index advances per accepted beat and wraps to 0 after the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

`ifdef POPCOUNT_EXPANDER_ROTATE_EN
  logic [CW-1:0] rot;
  logic [CW:0]   pos_sum;

  // Rotation offset moves by one position after every completed frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot <= '0;
    end else if (inc && last) begin
      rot <= (rot == LAST_IDX) ? '0 : rot + 1'b1;
    end
  end

  // pos = (idx + N - rot) mod N; the sum stays below 2N so one subtract suffices
  assign pos_sum = {1'b0, idx} + (CW+1)'(N) - {1'b0, rot};
  assign pos     = (pos_sum >= (CW+1)'(N)) ? CW'(pos_sum - (CW+1)'(N)) : CW'(pos_sum);
`else
  assign pos = idx;
`endif

endmodule

// File: rtl/popcount_expander.sv
// Count-to-frame expander: accepts a count 0..N and serialises an N-bit
// frame holding exactly min(count, N) ones, index 0 first. Counts above N
// saturate and raise a sticky flag. A new count may be taken on the
// accepted last beat so frames run back to back.
// Optional feature macro: POPCOUNT_EXPANDER_ROTATE_EN (rotating ones position).
module popcount_expander
  import popcount_expander_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = count_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic          sat_flag
);

  localparam logic [CW-1:0] N_CNT = CW'(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pos;
  logic          last;
  logic          accept;
  logic          beat;
  logic          over;

  assign out_valid = (state == EMIT);
  assign beat      = out_valid && out_ready;
  assign out_last  = out_valid && last;
  assign out_bit   = out_valid && (pos < cnt);
  assign over      = (in_count > N_CNT);

  // Ready in IDLE, or on the last beat being accepted; held low during reset
  assign in_ready = !rst && ((state == IDLE) || (beat && last));
  assign accept   = in_valid && in_ready;

  popcount_expander_idx #(
    .N  (N),
    .CW (CW)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .inc  (beat),
    .clr  (accept),
    .pos  (pos),
    .last (last)
  );

  // FSM, saturating count latch and sticky saturation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      state <= EMIT;
      cnt   <= over ? N_CNT : in_count;
      if (over) begin
        sat_flag <= 1'b1;
      end
    end else if (beat && last) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_popcount_expander.sv
// Directed bench for popcount_expander (N=5): thermometer frames,
// saturation, back-to-back frames, stalls, mid-frame reset and the
// optional rotation feature (POPCOUNT_EXPANDER_ROTATE_EN).
module tb_popcount_expander;

  localparam int N  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;
  logic          sat_flag;

  int checks = 0;
  int errors = 0;

  popcount_expander #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
    tick; tick;
    checks++;
    if ({out_valid, out_bit, out_last, sat_flag, in_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got v/b/l/s/r=%b want 00000",
               {out_valid, out_bit, out_last, sat_flag, in_ready});
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_idle got valid/ready=%b want 01", {out_valid, in_ready});
    end
    $display("reset released, idle");
  endtask

  task automatic test_thermometer;
    logic [2:0] got, want;
    in_valid = 1'b1; in_count = 3'd3; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL therm_in_ready got %b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    for (int b = 0; b < N; b++) begin
      got  = {out_valid, out_bit, out_last};
      want = {1'b1, (b < 3), (b == N - 1)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL therm_beat%0d got v/b/l=%b want %b", b, got, want);
      end
      tick;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL therm_idle got out_valid=%b want 0", out_valid);
    end
    $display("frame count=3 expected 11100");
  endtask

  task automatic test_saturate;
    logic [3:0] got, want;
    in_valid = 1'b1; in_count = 3'd7; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int b = 0; b < N; b++) begin
      got  = {out_valid, out_bit, out_last, sat_flag};
      want = {1'b1, 1'b1, (b == N - 1), 1'b1};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sat_beat%0d got v/b/l/s=%b want %b", b, got, want);
      end
      tick;
    end
    in_valid = 1'b1; in_count = 3'd1;
    tick;
    in_valid = 1'b0;
    for (int b = 0; b < N; b++) begin
      got  = {out_valid, out_bit, out_last, sat_flag};
      want = {1'b1, (b < 1), (b == N - 1), 1'b1};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sat_sticky_beat%0d got v/b/l/s=%b want %b", b, got, want);
      end
      tick;
    end
    $display("frame count=7 expected 11111 then count=1 expected 10000, sat_flag sticky");
  endtask

  task automatic test_back_to_back;
    logic [3:0] got, want;
    in_valid = 1'b1; in_count = 3'd0; out_ready = 1'b1;
    tick;
    in_count = 3'd5;
    for (int b = 0; b < 2 * N; b++) begin
      got  = {out_valid, out_bit, out_last, in_ready};
      want = {1'b1, (b >= N), (b == N - 1) || (b == 2 * N - 1), (b == N - 1) || (b == 2 * N - 1)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_beat%0d got v/b/l/r=%b want %b", b, got, want);
      end
      if (b == N) in_valid = 1'b0;
      tick;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got out_valid=%b want 0", out_valid);
    end
    $display("frames count=0 then count=5 expected 00000 11111 in 10 cycles");
  endtask

  task automatic test_stall;
    logic [2:0] got, want;
    int k;
    int c;
    in_valid = 1'b1; in_count = 3'd2; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    k = 0;
    c = 0;
    while (k < N && c < 20) begin
      got  = {out_valid, out_bit, out_last};
      want = {1'b1, (k < 2), (k == N - 1)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall_cycle%0d_bit%0d got v/b/l=%b want %b", c, k, got, want);
      end
      out_ready = (c % 2 == 0);
      tick;
      if (out_ready) k++;
      c++;
    end
    out_ready = 1'b1;
    checks++;
    if (k != N || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done got bits=%0d valid=%b want %0d 0", k, out_valid, N);
    end
    $display("frame count=2 with toggling out_ready expected 11000");
  endtask

  task automatic test_reset_mid;
    logic [4:0] got;
    in_valid = 1'b1; in_count = 3'd3; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    checks++;
    if ({out_valid, out_bit, out_last} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_pre got v/b/l=%b want 110", {out_valid, out_bit, out_last});
    end
    rst = 1'b1;
    #1;
    got = {out_valid, out_bit, out_last, sat_flag, in_ready};
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_outputs got v/b/l/s/r=%b want 00000", got);
    end
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({out_valid, out_last, in_ready, sat_flag} !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_idle got v/l/r/s=%b want 0010",
               {out_valid, out_last, in_ready, sat_flag});
    end
    $display("reset mid-frame at bit 2, frame abandoned");
  endtask

  task automatic test_rotate;
    logic [2:0] got, want;
    logic       exp_bit;
    int         ones;
    for (int f = 0; f < N; f++) begin
      in_valid = 1'b1; in_count = 3'd1; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      ones = 0;
      for (int b = 0; b < N; b++) begin
`ifdef POPCOUNT_EXPANDER_ROTATE_EN
        exp_bit = (b == f);
`else
        exp_bit = (b == 0);
`endif
        got  = {out_valid, out_bit, out_last};
        want = {1'b1, exp_bit, (b == N - 1)};
        if (out_bit === 1'b1) ones++;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL rot_frame%0d_beat%0d got v/b/l=%b want %b", f, b, got, want);
        end
        tick;
      end
      checks++;
      if (ones != 1) begin
        errors++;
        $display("FAIL rot_frame%0d_popcount got %0d want 1", f, ones);
      end
      $display("frame %0d count=1 popcount=%0d", f, ones);
    end
  endtask

  initial begin
    test_reset;
    test_thermometer;
    test_saturate;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_rotate;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
